// File: rtl/beam_sum_accumulator.sv
// rtl/beam_sum_accumulator.sv - saturating accumulator summing NUM_CH signed channel samples into one beam sample
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   inData    signed channel sample (WIDTH bits)
//   inValid   inData valid this cycle
//   inReady   block accepts inData this cycle (high only while collecting)
//   outData   saturated beam sum (WIDTH bits)
//   outValid  outData/outOvf valid, held until taken
//   outReady  downstream accepts outData this cycle
//   outOvf    at least one add in this beam saturated
//   chIdx     index of the next channel expected, 0..NUM_CH-1
module beam_sum_accumulator #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inData,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    input  logic             outReady,
    output logic             outOvf,
    output logic [7:0]       chIdx
);

    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;

    localparam logic [WIDTH-1:0] POS_RAIL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_RAIL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [7:0]       LAST_CH  = 8'(NUM_CH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_sticky;
    logic [7:0]       r_ch_idx;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_ovf;

    logic             w_accept;
    logic             w_taken;
    logic             w_last;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;
    logic             w_sticky;

    assign w_accept = inValid && inReady;
    assign w_taken  = r_out_valid && outReady;
    assign w_last   = (r_ch_idx == LAST_CH);

    // Channel 0 starts a new beam, so the previous beam's sum is ignored
    // rather than cleared in a separate cycle.
    assign w_a   = (r_ch_idx == 8'd0) ? '0 : r_acc;
    assign w_sum = w_a + inData;

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    assign w_ovf    = (w_a[WIDTH-1] == inData[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    assign w_result = w_ovf ? (inData[WIDTH-1] ? NEG_RAIL : POS_RAIL) : w_sum;
    assign w_sticky = (r_ch_idx == 8'd0) ? w_ovf : (r_sticky | w_ovf);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_ACCUM: if (w_accept && w_last) w_next_state = S_HOLD;
            S_HOLD:  if (w_taken)            w_next_state = S_ACCUM;
            default:                         w_next_state = S_ACCUM;
        endcase
    end

    // Output logic: readiness depends on state only, never on inValid.
    always_comb begin
        inReady = 1'b0;
        if (r_state == S_ACCUM) inReady = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_ch_idx    <= 8'd0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc    <= w_result;
                        r_sticky <= w_sticky;
                        if (w_last) begin
                            r_out_data  <= w_result;
                            r_out_ovf   <= w_sticky;
                            r_out_valid <= 1'b1;
                            r_ch_idx    <= 8'd0;
                        end else begin
                            r_ch_idx <= r_ch_idx + 8'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_taken) r_out_valid <= 1'b0;
                end
                default: begin
                    // Unused encoding: recover to a clean beam start.
                    r_ch_idx    <= 8'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign outData  = r_out_data;
    assign outValid = r_out_valid;
    assign outOvf   = r_out_ovf;
    assign chIdx    = r_ch_idx;

endmodule
